// File: rtl/pcjr_bus_hold_arbiter_if.sv
// Purpose : groups the CPU hold/ready handshake, the decoded I/O strobes and
//           the secondary requester handshake into one bundle.
// Latency : none; the bundle contains no logic.
// Backpressure: requester holds req until grant; the CPU answers HOLD with HLDA.
// Modports:
//   master - the arbiter: drives HOLD, RDY, grant and hold_timeout.
//   slave  - the surroundings (CPU, decoder, requester): drive everything else.
interface pcjr_bus_hold_arbiter_if;
    logic cpu_clock_posedge;
    logic cpu_clock_negedge;
    logic IOR_N;
    logic IOW_N;
    logic HLDA;
    logic HOLD;
    logic RDY;
    logic req;
    logic done;
    logic grant;
    logic hold_timeout;

    modport master (
        input  cpu_clock_posedge,
        input  cpu_clock_negedge,
        input  IOR_N,
        input  IOW_N,
        input  HLDA,
        input  req,
        input  done,
        output HOLD,
        output RDY,
        output grant,
        output hold_timeout
    );

    modport slave (
        output cpu_clock_posedge,
        output cpu_clock_negedge,
        output IOR_N,
        output IOW_N,
        output HLDA,
        output req,
        output done,
        input  HOLD,
        input  RDY,
        input  grant,
        input  hold_timeout
    );
endinterface

// File: rtl/pcjr_bus_hold_arbiter.sv
// Purpose : shares the PCjr bus between the 8088 and a secondary requester via
//           HOLD/HLDA, and stretches I/O commands with RDY wait states.
// Latency : every output is registered; one system clock after the deciding
//           CPU-clock enable.
// Backpressure: requester is held off by the idle guard after each release and
//           is forcibly released after MAX_HOLD CPU clocks; CPU is stalled via RDY.
// Ports:
//   clock, reset - system clock and asynchronous active-high reset.
//   bus          - arbiter side of pcjr_bus_hold_arbiter_if (see that file).
module pcjr_bus_hold_arbiter #(
    parameter int WAIT_STATES = 1,
    parameter int MAX_HOLD    = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    pcjr_bus_hold_arbiter_if.master         bus
);

    localparam logic [2:0] WS_LOAD    = 3'(WAIT_STATES);
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       hold_q, hold_d;
    logic       grant_q, grant_d;
    logic       timeout_q, timeout_d;
    logic       guard_q, guard_d;
    logic       done_lat_q, done_lat_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;

    logic       cmd, cmd_q, cmd_rise;
    logic       rdy_q, rdy_d;
    logic [2:0] ws_cnt_q, ws_cnt_d;

    logic       done_seen;
    logic       at_limit;

    // A done pulse between CPU-clock enables is remembered until the next one.
    assign done_seen = bus.done | done_lat_q;
    assign at_limit  = (hold_cnt_q >= HOLD_LIMIT);

    assign cmd      = ~(bus.IOR_N & bus.IOW_N);
    assign cmd_rise = cmd & ~cmd_q;

    // ------------------------------------------------------------------
    // Hold FSM: moves only on CPU-clock rising-edge enables.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        grant_d    = grant_q;
        timeout_d  = 1'b0;
        guard_d    = guard_q;
        hold_cnt_d = hold_cnt_q;
        done_lat_d = done_lat_q | bus.done;

        if (bus.cpu_clock_posedge) begin
            done_lat_d = 1'b0;
            // The guard only ever lives for one enable interval.
            guard_d    = 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req && !guard_q) begin
                        state_d = REQ;
                        hold_d  = 1'b1;
                    end
                end
                REQ: begin
                    // A withdrawn request wins over a late HLDA.
                    if (!bus.req) begin
                        state_d = IDLE;
                        hold_d  = 1'b0;
                    end else if (bus.HLDA) begin
                        state_d    = GRANT;
                        grant_d    = 1'b1;
                        hold_cnt_d = 8'd0;
                    end
                end
                GRANT: begin
                    if (done_seen || !bus.req || at_limit) begin
                        state_d   = RELEASE;
                        hold_d    = 1'b0;
                        grant_d   = 1'b0;
                        timeout_d = at_limit;
                    end else if (hold_cnt_q != 8'hFF) begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
                RELEASE: begin
                    if (!bus.HLDA) begin
                        state_d = IDLE;
                        guard_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Wait-state engine. RDY low marks "counting"; commands arriving then
    // are ignored. The CPU is floated during GRANT, so RDY is held high.
    // ------------------------------------------------------------------
    always_comb begin
        rdy_d    = rdy_q;
        ws_cnt_d = ws_cnt_q;
        if (grant_d) begin
            rdy_d    = 1'b1;
            ws_cnt_d = 3'd0;
        end else if (!rdy_q) begin
            if (ws_cnt_q == 3'd0) begin
                rdy_d = 1'b1;
            end else if (bus.cpu_clock_negedge) begin
                ws_cnt_d = ws_cnt_q - 3'd1;
            end
        end else if (cmd_rise && (WS_LOAD != 3'd0)) begin
            rdy_d    = 1'b0;
            ws_cnt_d = WS_LOAD;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_q     <= 1'b0;
            grant_q    <= 1'b0;
            timeout_q  <= 1'b0;
            guard_q    <= 1'b0;
            done_lat_q <= 1'b0;
            hold_cnt_q <= 8'd0;
            cmd_q      <= 1'b0;
            rdy_q      <= 1'b1;
            ws_cnt_q   <= 3'd0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            grant_q    <= grant_d;
            timeout_q  <= timeout_d;
            guard_q    <= guard_d;
            done_lat_q <= done_lat_d;
            hold_cnt_q <= hold_cnt_d;
            cmd_q      <= cmd;
            rdy_q      <= rdy_d;
            ws_cnt_q   <= ws_cnt_d;
        end
    end

    assign bus.HOLD         = hold_q;
    assign bus.grant        = grant_q;
    assign bus.RDY          = rdy_q;
    assign bus.hold_timeout = timeout_q;

endmodule

// File: tb/tb_pcjr_bus_hold_arbiter.sv
// Purpose : exercises two arbiter instances (WS=3/MAX_HOLD=4 and WS=0/MAX_HOLD=8)
//           against a behavioural model of the hold and wait-state rules.
// Latency : outputs sampled 1 ns after each system clock rising edge.
// Backpressure: HLDA is driven CPU-like (following HOLD) or randomly.
module tb_pcjr_bus_hold_arbiter;

    localparam int WS_A = 3;
    localparam int MH_A = 4;
    localparam int WS_B = 0;
    localparam int MH_B = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic pos_en = 1'b0;
    logic neg_en = 1'b0;
    logic ior_n  = 1'b1;
    logic iow_n  = 1'b1;
    logic hlda   = 1'b0;
    logic req    = 1'b0;
    logic done   = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    pcjr_bus_hold_arbiter_if bus_a ();
    pcjr_bus_hold_arbiter_if bus_b ();

    assign bus_a.cpu_clock_posedge = pos_en;
    assign bus_a.cpu_clock_negedge = neg_en;
    assign bus_a.IOR_N             = ior_n;
    assign bus_a.IOW_N             = iow_n;
    assign bus_a.HLDA              = hlda;
    assign bus_a.req               = req;
    assign bus_a.done              = done;
    assign bus_b.cpu_clock_posedge = pos_en;
    assign bus_b.cpu_clock_negedge = neg_en;
    assign bus_b.IOR_N             = ior_n;
    assign bus_b.IOW_N             = iow_n;
    assign bus_b.HLDA              = hlda;
    assign bus_b.req               = req;
    assign bus_b.done              = done;

    pcjr_bus_hold_arbiter #(.WAIT_STATES(WS_A), .MAX_HOLD(MH_A)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    pcjr_bus_hold_arbiter #(.WAIT_STATES(WS_B), .MAX_HOLD(MH_B)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clock = ~clock;

    // Behavioural model: who owns the bus, expressed as flags per instance.
    bit m_hold  [2];
    bit m_grant [2];
    bit m_rdy   [2];
    bit m_to    [2];
    bit m_drain [2];   // bus given back, waiting for the CPU to drop HLDA
    bit m_guard [2];   // CPU owed one full clock before the next hold
    bit m_dlat  [2];
    bit m_cprev [2];
    int m_held  [2];   // CPU clocks spent granted
    int m_left  [2];   // negedge enables still to wait

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_hold[d] = 0; m_grant[d] = 0; m_rdy[d] = 1; m_to[d] = 0;
            m_drain[d] = 0; m_guard[d] = 0; m_dlat[d] = 0; m_cprev[d] = 0;
            m_held[d] = 0; m_left[d] = 0;
        end
    endtask

    task automatic model_clock();
        for (int d = 0; d < 2; d++) begin
            int mh;
            int ws;
            bit cmd;
            bit rise;
            bit dn;
            mh   = (d == 0) ? MH_A : MH_B;
            ws   = (d == 0) ? WS_A : WS_B;
            cmd  = !(ior_n && iow_n);
            rise = cmd && !m_cprev[d];
            dn   = done || m_dlat[d];
            m_cprev[d] = cmd;
            m_to[d]    = 0;
            if (pos_en) begin
                m_dlat[d] = 0;
                if (m_drain[d]) begin
                    if (!hlda) begin
                        m_drain[d] = 0;
                        m_guard[d] = 1;
                    end
                end else if (m_grant[d]) begin
                    if (dn || !req || m_held[d] >= mh - 1) begin
                        m_to[d]    = (m_held[d] >= mh - 1);
                        m_grant[d] = 0;
                        m_hold[d]  = 0;
                        m_drain[d] = 1;
                    end else if (m_held[d] < 255) begin
                        m_held[d]++;
                    end
                end else if (m_hold[d]) begin
                    if (!req) m_hold[d] = 0;
                    else if (hlda) begin
                        m_grant[d] = 1;
                        m_held[d]  = 0;
                    end
                end else if (m_guard[d]) begin
                    m_guard[d] = 0;
                end else if (req) begin
                    m_hold[d] = 1;
                end
            end else if (done) begin
                m_dlat[d] = 1;
            end
            if (m_grant[d]) begin
                m_rdy[d]  = 1;
                m_left[d] = 0;
            end else if (!m_rdy[d]) begin
                if (m_left[d] == 0) m_rdy[d] = 1;
                else if (neg_en) m_left[d]--;
            end else if (rise && ws > 0) begin
                m_rdy[d]  = 0;
                m_left[d] = ws;
            end
        end
    endtask

    function automatic logic [3:0] m_vec(int d);
        return {m_hold[d], m_grant[d], m_rdy[d], m_to[d]};
    endfunction

    function automatic logic [3:0] obs_a();
        return {bus_a.HOLD, bus_a.grant, bus_a.RDY, bus_a.hold_timeout};
    endfunction

    function automatic logic [3:0] obs_b();
        return {bus_b.HOLD, bus_b.grant, bus_b.RDY, bus_b.hold_timeout};
    endfunction

    // One system clock: CPU clock is 4 system clocks, posedge enable first.
    task automatic step();
        pos_en = (cyc % 4 == 0);
        neg_en = (cyc % 4 == 2);
        @(posedge clock);
        if (reset) model_reset();
        else model_clock();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if (obs_a() !== 4'b0010) begin
            errors++;
            $display("FAIL reset_a got=%b exp=0010 {HOLD,grant,RDY,to}", obs_a());
        end
        checks++;
        if (obs_b() !== 4'b0010) begin
            errors++;
            $display("FAIL reset_b got=%b exp=0010 {HOLD,grant,RDY,to}", obs_b());
        end
        reset = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_basic_grant();
        bit found;
        bit g_before;
        bit to_seen;
        int genab;
        found = 0; to_seen = 0; genab = 0;
        req = 1; hlda = 0;
        for (int i = 0; i < 16 && !found; i++) begin
            step();
            if (bus_a.HOLD) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL basic_hold_rise got=0 exp=1"); end
        hlda = 1;
        found = 0;
        for (int i = 0; i < 16 && !found; i++) begin
            step();
            if (bus_a.grant) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL basic_grant_rise got=0 exp=1"); end
        repeat (9) step();
        done = 1;
        step();
        done = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            g_before = bus_a.grant;
            step();
            if (pos_en && g_before) genab++;
            if (bus_a.hold_timeout) to_seen = 1;
            if (!bus_a.grant) found = 1;
        end
        // the 10 steps before the loop also saw grant high through 2 enables
        genab += 2;
        checks++;
        if (!found || genab !== 3) begin
            errors++;
            $display("FAIL basic_grant_len got=%0d exp=3 (released=%0d)", genab, found);
        end
        checks++;
        if (bus_a.HOLD !== 1'b0) begin
            errors++; $display("FAIL basic_hold_drop got=%b exp=0", bus_a.HOLD);
        end
        checks++;
        if (to_seen) begin errors++; $display("FAIL basic_no_timeout got=1 exp=0"); end
        req = 0; hlda = 0;
        repeat (16) step();
    endtask

    task automatic test_timeout();
        bit found;
        bit g_before;
        bit h_before;
        bit l_before;
        int genab;
        int tos;
        int idle_en;
        found = 0; genab = 0; tos = 0; idle_en = 0;
        req = 1;
        for (int i = 0; i < 40 && !found; i++) begin
            hlda = bus_a.HOLD;
            step();
            if (bus_a.grant) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL to_grant_rise got=0 exp=1"); end
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            hlda = bus_a.HOLD;
            g_before = bus_a.grant;
            step();
            if (pos_en && g_before) genab++;
            if (bus_a.hold_timeout) tos++;
            if (!bus_a.grant) found = 1;
        end
        checks++;
        if (genab !== MH_A) begin
            errors++; $display("FAIL to_grant_len got=%0d exp=%0d", genab, MH_A);
        end
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            hlda = bus_a.HOLD;
            h_before = bus_a.HOLD;
            l_before = hlda;
            step();
            if (pos_en && !h_before && !l_before) idle_en++;
            if (bus_a.hold_timeout) tos++;
            if (bus_a.HOLD) found = 1;
        end
        checks++;
        if (tos !== 1) begin errors++; $display("FAIL to_pulse_count got=%0d exp=1", tos); end
        checks++;
        if (!found || idle_en < 3) begin
            errors++;
            $display("FAIL to_idle_gap got=%0d enables exp>=3 (rehold=%0d)", idle_en, found);
        end
        req = 0; hlda = 0;
        repeat (40) step();
    endtask

    task automatic test_abort();
        bit found;
        bit g_seen;
        int waited;
        found = 0; g_seen = 0; waited = 0;
        req = 1; hlda = 0;
        for (int i = 0; i < 16 && !found; i++) begin
            step();
            if (bus_a.HOLD) found = 1;
        end
        req = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus_a.grant) g_seen = 1;
        end
        checks++;
        if (!found || bus_a.HOLD !== 1'b0 || g_seen) begin
            errors++;
            $display("FAIL abort_drop got HOLD=%b grant_seen=%0d exp HOLD=0 grant_seen=0", bus_a.HOLD, g_seen);
        end
        req = 1;
        found = 0;
        for (int i = 0; i < 16 && !found; i++) begin
            step();
            waited++;
            if (bus_a.HOLD) found = 1;
        end
        checks++;
        if (!found || waited > 4) begin
            errors++; $display("FAIL abort_rehold got=%0d clocks exp<=4", waited);
        end
        req = 0; hlda = 1;
        g_seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus_a.grant || bus_b.grant) g_seen = 1;
        end
        checks++;
        if (bus_a.HOLD !== 1'b0 || g_seen) begin
            errors++;
            $display("FAIL abort_race got HOLD=%b grant_seen=%0d exp HOLD=0 grant_seen=0", bus_a.HOLD, g_seen);
        end
        hlda = 0;
        repeat (8) step();
    endtask

    task automatic test_wait_states();
        int c0;
        int c3;
        int n;
        int low;
        bit ended;
        int b_low;
        b_low = 0;
        c0 = cyc;
        n = 0; c3 = c0;
        for (int c = c0 + 1; n < WS_A; c++) begin
            if (c % 4 == 2) begin n++; c3 = c; end
        end
        ior_n = 0;
        step();
        checks++;
        if (bus_a.RDY !== 1'b0) begin
            errors++; $display("FAIL ws_fall got=%b exp=0", bus_a.RDY);
        end
        if (bus_b.RDY !== 1'b1) b_low++;
        low = (bus_a.RDY === 1'b0) ? 1 : 0;
        ended = 0;
        for (int i = 0; i < 40 && !ended; i++) begin
            if (i == 2) ior_n = 1;
            if (i == 4) iow_n = 0;
            step();
            if (bus_b.RDY !== 1'b1) b_low++;
            if (bus_a.RDY === 1'b0) low++;
            else ended = 1;
        end
        checks++;
        if (low !== c3 - c0 + 1) begin
            errors++; $display("FAIL ws_low_len got=%0d clocks exp=%0d", low, c3 - c0 + 1);
        end
        iow_n = 1;
        ended = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus_a.RDY !== 1'b1) ended = 1;
            if (bus_b.RDY !== 1'b1) b_low++;
        end
        checks++;
        if (ended) begin errors++; $display("FAIL ws_no_extend got=low exp=high"); end
        checks++;
        if (b_low !== 0) begin
            errors++; $display("FAIL ws_zero_rdy got=%0d low clocks exp=0", b_low);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(11, 0) == 0) req = ~req;
            if ($urandom_range(2, 0) == 0) hlda = bus_a.HOLD | bus_b.HOLD;
            else if ($urandom_range(19, 0) == 0) hlda = ~hlda;
            done  = ($urandom_range(15, 0) == 0);
            if ($urandom_range(9, 0) == 0) ior_n = ~ior_n;
            if ($urandom_range(9, 0) == 0) iow_n = ~iow_n;
            step();
            checks++;
            if (obs_a() !== m_vec(0)) begin
                errors++;
                $display("FAIL rand_a cyc=%0d got=%b exp=%b", cyc, obs_a(), m_vec(0));
            end
            checks++;
            if (obs_b() !== m_vec(1)) begin
                errors++;
                $display("FAIL rand_b cyc=%0d got=%b exp=%b", cyc, obs_b(), m_vec(1));
            end
        end
        req = 0; hlda = 0; done = 0; ior_n = 1; iow_n = 1;
        repeat (40) step();
    endtask

    task automatic test_reset_mid_grant();
        bit found;
        found = 0;
        req = 1;
        for (int i = 0; i < 40 && !found; i++) begin
            hlda = bus_a.HOLD;
            step();
            if (bus_a.grant) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rst_grant_rise got=0 exp=1"); end
        repeat (5) step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs_a() !== 4'b0010) begin
            errors++; $display("FAIL rst_async_a got=%b exp=0010", obs_a());
        end
        checks++;
        if (obs_b() !== 4'b0010) begin
            errors++; $display("FAIL rst_async_b got=%b exp=0010", obs_b());
        end
        model_reset();
        step();
        reset = 1'b0;
        hlda = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (obs_a() !== m_vec(0)) begin
                errors++;
                $display("FAIL rst_after_a cyc=%0d got=%b exp=%b", cyc, obs_a(), m_vec(0));
            end
        end
        req = 0;
        repeat (8) step();
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_timeout();
        test_abort();
        test_wait_states();
        test_random();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
